// File: rtl/onehot_decoder_seq_if.sv
// Handshake and output bundle for onehot_decoder_seq: code/valid in, ready/y/busy/done out.
interface onehot_decoder_seq_if;
  logic [1:0] code;
  logic       valid;
  logic       ready;
  logic [3:0] y;
  logic       busy;
  logic       done;

  modport master (
    output code,
    output valid,
    input  ready,
    input  y,
    input  busy,
    input  done
  );

  modport slave (
    input  code,
    input  valid,
    output ready,
    output y,
    output busy,
    output done
  );
endinterface

// File: rtl/onehot_decoder_seq.sv
// Registered 2-to-4 one-hot decoder that holds each accepted pattern for HOLD cycles.
// Optional macro ONEHOT_DEC_STICKY_EN keeps the last pattern on y after the hold ends.
module onehot_decoder_seq #(
  parameter int unsigned HOLD = 10
) (
  input logic                 clk,
  input logic                 rst,
  onehot_decoder_seq_if.slave bus
);

  typedef enum logic [0:0] {
    StIdle,
    StDrive
  } state_e;

  localparam logic [7:0] LastCnt = 8'(HOLD - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] y_q, y_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      y_q     <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.valid) begin
          state_d = StDrive;
          y_d     = 4'b0001 << bus.code;
          cnt_d   = 8'd0;
          busy_d  = 1'b1;
        end
      end
      StDrive: begin
        // valid/code are deliberately not looked at here: no queuing while holding
        if (cnt_q == LastCnt) begin
          state_d = StIdle;
          cnt_d   = 8'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`ifdef ONEHOT_DEC_STICKY_EN
          y_d     = y_q;
`else
          y_d     = 4'b0000;
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.ready = (state_q == StIdle);
  assign bus.y     = y_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

  a_y_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(y_q));
  a_busy_state: assert property (@(posedge clk) disable iff (rst)
                                 busy_q == (state_q == StDrive));
  a_done_idle: assert property (@(posedge clk) disable iff (rst) done_q |-> !busy_q);

endmodule

// File: doc/onehot_decoder_seq.md
ONEHOT_DECODER_SEQ -- requirements
Module: onehot_decoder_seq

Interface
REQ-001 SHALL have parameter HOLD, default 10: number of clk cycles each one-hot output pattern is driven; legal range 1..255.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port code  input  2  binary index of the line to assert (0..3).
REQ-005 SHALL have port valid  input  1  code is valid this cycle.
REQ-006 SHALL have port ready  output  1  block can accept a code this cycle.
REQ-007 SHALL have port y  output  4  registered one-hot line outputs, y[n] asserted for code n.
REQ-008 SHALL have port busy  output  1  high while a pattern is being held.
REQ-009 SHALL have port done  output  1  one-cycle pulse when a hold period completes.

Function
REQ-010 SHALL implement states IDLE and DRIVE with an 8-bit hold counter cnt.
REQ-011 SHALL drive ready=1 only in IDLE and ready=0 in DRIVE, combinationally from state.
REQ-012 SHALL accept a code when valid=1 and ready=1 at a rising edge; accept moves IDLE->DRIVE, loads y=1<<code, cnt=0, busy=1.
REQ-013 SHALL make y valid the cycle after the accepting edge (one-cycle latency), unchanged for exactly HOLD cycles.
REQ-014 SHALL increment cnt each DRIVE cycle; at cnt==HOLD-1 go to IDLE, set busy=0, pulse done=1 for one cycle, and clear y to 4'b0000 (unless REQ-021 applies).
REQ-015 SHALL ignore valid and code while in DRIVE; no queuing, no effect on y or cnt.
REQ-016 SHALL allow back-to-back operation: a code presented with valid=1 in the cycle done=1 is accepted at that edge, giving a HOLD-cycle gap-free sequence except the single IDLE cycle.
REQ-017 SHALL guarantee y has at most one bit set at all times (y is 4'b0000 or one-hot).
REQ-018 SHALL with HOLD=1 hold each pattern one cycle and pulse done in the following cycle.

Reset
REQ-019 SHALL on rst=1 at a rising edge force state=IDLE, cnt=0, y=4'b0000, busy=0, done=0, taking priority over valid and any hold in progress.
REQ-020 SHALL abort a DRIVE in progress on reset without emitting done; ready=1 the cycle after rst deasserts.

Configuration
REQ-021 SHALL, when macro ONEHOT_DEC_STICKY_EN is defined, keep the last one-hot pattern on y after the hold period ends until the next accept or reset; done/busy timing unchanged.
REQ-022 SHALL, when ONEHOT_DEC_STICKY_EN is not defined, clear y to 4'b0000 at hold end as in REQ-014.

Verification
REQ-023 SHALL cover: HOLD=10, reset then code=0 valid=1 for 1 cycle -> y=0001 for 10 cycles, done pulse next, y=0000, ready=1.
REQ-024 SHALL cover: codes 1,2,3 presented back-to-back with valid held high -> y=0010,0100,1000 each for 10 cycles, one IDLE cycle between, three done pulses.
REQ-025 SHALL cover: code=2 accepted, then code=3 valid=1 during DRIVE -> y stays 0100 for full hold, code 3 accepted only when ready=1.
REQ-026 SHALL cover: rst=1 at cycle 4 of a hold of code=1 -> next cycle y=0000, busy=0, done never pulses, ready=1.
REQ-027 SHALL cover: ONEHOT_DEC_STICKY_EN defined, code=3 accepted, no further valid -> y=1000 remains after done pulse until rst.
REQ-028 SHALL cover: HOLD=1, codes 0..3 streamed -> each pattern one cycle, alternating with IDLE cycles, done pulses after each.
